rs255_251_encoder: RTL

// - Systematic RS(255,251) encoder over GF(256), primitive poly 0x11D, alpha=0x02; transmit-side counterpart of the syndrome checker.
// - Passes message bytes straight through, then appends 4 parity bytes computed by an LFSR divider.
// - Generator roots are alpha^1..alpha^4: g(x)=x^4+0x1E x^3+0xD8 x^2+0xE7 x+0x74.
// - First byte in is the highest-power coefficient, so a codeword out of this block gives all-zero syndromes.

---
 rtl/rs_pkg.sv | 43 ++++
 rtl/gf256mul.sv | 14 +
 rtl/rs255_251_encoder.sv | 114 +++++++++++
 3 files changed

// File: rtl/rs_pkg.sv
// Shared constants, FSM state type and GF(256) arithmetic for the RS(255,251) encoder.
package rs_pkg;

    localparam logic [8:0] GF_POLY = 9'h11D;
    localparam int         NPAR    = 4;
    localparam int         RS_N    = 255;
    localparam int         RS_K    = RS_N - NPAR;

    // Generator g(x) = x^4 + G3 x^3 + G2 x^2 + G1 x + G0, roots alpha^1..alpha^4
    localparam logic [7:0] G3 = 8'h1E;
    localparam logic [7:0] G2 = 8'hD8;
    localparam logic [7:0] G1 = 8'hE7;
    localparam logic [7:0] G0 = 8'h74;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        DATA   = 2'd1,
        PARITY = 2'd2
    } state_t;

    function automatic logic [7:0] gen_coef(input int i);
        case (i)
            0:       return G0;
            1:       return G1;
            2:       return G2;
            default: return G3;
        endcase
    endfunction

    // Shift-and-add multiply, reducing by the field polynomial on each carry out of bit 7
    function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] acc;
        logic [7:0] sh;
        acc = 8'h00;
        sh  = a;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) acc = acc ^ sh;
            sh = sh[7] ? ((sh << 1) ^ GF_POLY[7:0]) : (sh << 1);
        end
        return acc;
    endfunction

endpackage

// File: rtl/gf256mul.sv
// Combinational GF(256) multiplier over poly 0x11D.
module gf256mul
    import rs_pkg::*;
(
    input  logic [7:0] a,
    input  logic [7:0] b,
    output logic [7:0] p
);

    always_comb begin
        p = gf_mul(a, b);
    end

endmodule

// File: rtl/rs255_251_encoder.sv
// Systematic RS(255,251) encoder: message bytes pass through, then four parity
// bytes from an LFSR divider by g(x) are appended, highest power first.
module rs255_251_encoder
    import rs_pkg::*;
#(
    parameter int MSG_MAX = RS_K
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       din_val,
    input  logic       din_sop,
    input  logic       din_eop,
    input  logic [7:0] din,
    output logic       din_rdy,
    output logic       dout_val,
    output logic       dout_sop,
    output logic       dout_eop,
    output logic [7:0] dout,
    output logic       len_err
);

    localparam logic [7:0] MAX_CNT = 8'(MSG_MAX);

    state_t                   state_reg;
    logic [7:0]               count_reg;
    logic [1:0]               pidx_reg;
    logic [NPAR-1:0][7:0]     lfsr_reg;
    logic [NPAR-1:0][7:0]     lfsr_next;
    logic [NPAR-1:0][7:0]     prod;
    logic [7:0]               fb;
    logic [7:0]               count_inc;
    logic                     accept;
    logic                     at_max;

    assign din_rdy   = (state_reg != PARITY);
    assign accept    = din_val && din_rdy;
    assign count_inc = count_reg + 8'd1;
    assign at_max    = (count_inc == MAX_CNT);

    // A sop byte always starts from a cleared divider, even when aborting a frame in DATA
    assign fb = din ^ (din_sop ? 8'h00 : lfsr_reg[NPAR-1]);

    generate
        for (genvar gi = 0; gi < NPAR; gi++) begin : g_tap
            gf256mul u_mul (
                .a (fb),
                .b (gen_coef(gi)),
                .p (prod[gi])
            );
            if (gi == 0) begin : g_low
                assign lfsr_next[gi] = prod[gi];
            end else begin : g_high
                assign lfsr_next[gi] = (din_sop ? 8'h00 : lfsr_reg[gi-1]) ^ prod[gi];
            end
        end
    endgenerate

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg <= IDLE;
            count_reg <= 8'd0;
            pidx_reg  <= 2'd0;
            lfsr_reg  <= '0;
            dout_val  <= 1'b0;
            dout_sop  <= 1'b0;
            dout_eop  <= 1'b0;
            dout      <= 8'h00;
            len_err   <= 1'b0;
        end else begin
            dout_val <= 1'b0;
            dout_sop <= 1'b0;
            dout_eop <= 1'b0;
            len_err  <= 1'b0;
            case (state_reg)
                IDLE, DATA: begin
                    if (accept && din_sop) begin
                        lfsr_reg  <= lfsr_next;
                        count_reg <= 8'd1;
                        dout      <= din;
                        dout_val  <= 1'b1;
                        dout_sop  <= 1'b1;
                        len_err   <= (state_reg == DATA);
                        pidx_reg  <= 2'd0;
                        state_reg <= din_eop ? PARITY : DATA;
                    end else if (accept && state_reg == DATA) begin
                        lfsr_reg  <= lfsr_next;
                        count_reg <= count_inc;
                        dout      <= din;
                        dout_val  <= 1'b1;
                        if (din_eop || at_max) begin
                            state_reg <= PARITY;
                            pidx_reg  <= 2'd0;
                        end
                        // Forced close at the length limit is flagged only if the sender missed eop
                        if (at_max && !din_eop) len_err <= 1'b1;
                    end
                end
                PARITY: begin
                    dout     <= lfsr_reg[NPAR-1];
                    dout_val <= 1'b1;
                    lfsr_reg <= {lfsr_reg[NPAR-2:0], 8'h00};
                    pidx_reg <= pidx_reg + 2'd1;
                    if (pidx_reg == 2'(NPAR-1)) begin
                        dout_eop  <= 1'b1;
                        count_reg <= 8'd0;
                        state_reg <= IDLE;
                    end
                end
                default: state_reg <= IDLE;
            endcase
        end
    end

endmodule
